// File: rtl/ysyx_22050550_dcache_pkg.sv
// Shared constants and types for the direct-mapped, write-through data cache.
// Holds geometry, AXI encodings, FSM state encoding and the latched request record.
package ysyx_22050550_dcache_pkg;

    localparam int ADDR_W  = 64;
    localparam int NSET    = 16;
    localparam int LINE_DW = 2;

    localparam int OFF_W   = $clog2(LINE_DW);
    localparam int IDX_W   = $clog2(NSET);
    localparam int IDX_LSB = 3 + OFF_W;
    localparam int TAG_LSB = 3 + OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_DW - 1);
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [OFF_W-1:0] off_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_e;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
        logic [7:0]        wmask;
    } req_t;

endpackage

// File: rtl/ysyx_22050550_dcache_if.sv
// LSU request port and AXI4 master port of the data cache.
// The cache uses lsu_if.slave and axi_if.master.
interface ysyx_22050550_dcache_lsu_if;
    import ysyx_22050550_dcache_pkg::*;

    logic              io_Cache_valid;
    logic              io_Cache_op;
    logic [ADDR_W-1:0] io_Cache_addr;
    logic [63:0]       io_Cache_wdata;
    logic [7:0]        io_Cache_wmask;
    logic [63:0]       io_Cache_data;
    logic              io_Cache_dataok;

    modport master (
        output io_Cache_valid, io_Cache_op, io_Cache_addr, io_Cache_wdata, io_Cache_wmask,
        input  io_Cache_data, io_Cache_dataok
    );

    modport slave (
        input  io_Cache_valid, io_Cache_op, io_Cache_addr, io_Cache_wdata, io_Cache_wmask,
        output io_Cache_data, io_Cache_dataok
    );
endinterface

interface ysyx_22050550_dcache_axi_if;
    import ysyx_22050550_dcache_pkg::*;

    logic              io_ar_valid;
    logic              io_ar_ready;
    logic [ADDR_W-1:0] io_ar_addr;
    logic [7:0]        io_ar_len;
    logic [2:0]        io_ar_size;
    logic [1:0]        io_ar_burst;
    logic              io_r_valid;
    logic              io_r_ready;
    logic [63:0]       io_r_rdata;
    logic              io_r_rlast;
    logic              io_aw_valid;
    logic              io_aw_ready;
    logic [ADDR_W-1:0] io_aw_addr;
    logic [7:0]        io_aw_len;
    logic [2:0]        io_aw_size;
    logic [1:0]        io_aw_burst;
    logic              io_w_valid;
    logic              io_w_ready;
    logic [63:0]       io_w_data;
    logic [7:0]        io_w_strb;
    logic              io_w_last;
    logic              io_b_valid;
    logic              io_b_ready;

    modport master (
        output io_ar_valid, io_ar_addr, io_ar_len, io_ar_size, io_ar_burst,
        input  io_ar_ready,
        input  io_r_valid, io_r_rdata, io_r_rlast,
        output io_r_ready,
        output io_aw_valid, io_aw_addr, io_aw_len, io_aw_size, io_aw_burst,
        input  io_aw_ready,
        output io_w_valid, io_w_data, io_w_strb, io_w_last,
        input  io_w_ready,
        input  io_b_valid,
        output io_b_ready
    );

    modport slave (
        input  io_ar_valid, io_ar_addr, io_ar_len, io_ar_size, io_ar_burst,
        output io_ar_ready,
        output io_r_valid, io_r_rdata, io_r_rlast,
        input  io_r_ready,
        input  io_aw_valid, io_aw_addr, io_aw_len, io_aw_size, io_aw_burst,
        output io_aw_ready,
        input  io_w_valid, io_w_data, io_w_strb, io_w_last,
        output io_w_ready,
        output io_b_valid,
        input  io_b_ready
    );
endinterface

// File: rtl/ysyx_22050550_dcache_array.sv
// Valid/tag/data storage for the data cache: combinational read of one set,
// byte-masked store merge, per-beat line fill, and valid set/clear.
module ysyx_22050550_dcache_array
    import ysyx_22050550_dcache_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  idx_t                     i_idx,
    output logic                     o_valid,
    output tag_t                     o_tag,
    output logic [LINE_DW-1:0][63:0] o_line,
    input  logic                     i_wr_en,
    input  off_t                     i_wr_word,
    input  logic [63:0]              i_wr_data,
    input  logic [7:0]               i_wr_mask,
    input  logic                     i_fill_en,
    input  off_t                     i_fill_word,
    input  logic [63:0]              i_fill_data,
    input  logic                     i_set_valid,
    input  tag_t                     i_set_tag,
    input  logic                     i_clr_valid
);

    logic [NSET-1:0]           r_valid;
    tag_t                      r_tag  [NSET];
    logic [LINE_DW-1:0][63:0]  r_data [NSET];

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            if (i_clr_valid) r_valid[i_idx] <= 1'b0;
            if (i_set_valid) r_valid[i_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide whether they are trusted.
    always_ff @(posedge clock) begin
        if (i_set_valid) r_tag[i_idx] <= i_set_tag;
        if (i_fill_en) r_data[i_idx][i_fill_word] <= i_fill_data;
        if (i_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wr_mask[b]) r_data[i_idx][i_wr_word][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_22050550_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the LSU and AXI4.
// Reads refill a whole line with one INCR burst; writes go out as single-beat transactions.
module ysyx_22050550_dcache
    import ysyx_22050550_dcache_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    ysyx_22050550_dcache_lsu_if.slave   lsu,
    ysyx_22050550_dcache_axi_if.master  axi
);

    state_e r_state;
    state_e w_next;
    req_t   r_req;
    off_t   r_cnt;

    idx_t                     w_idx;
    tag_t                     w_tag;
    off_t                     w_word;
    logic                     w_arr_valid;
    tag_t                     w_arr_tag;
    logic [LINE_DW-1:0][63:0] w_arr_line;
    logic                     w_hit;
    logic                     w_last_beat;
    logic                     w_clr;
    logic                     w_wr;
    logic                     w_fill;
    logic                     w_set;

    assign w_idx       = r_req.addr[IDX_LSB +: IDX_W];
    assign w_tag       = r_req.addr[ADDR_W-1:TAG_LSB];
    assign w_word      = r_req.addr[3 +: OFF_W];
    assign w_hit       = w_arr_valid && (w_arr_tag == w_tag);
    assign w_last_beat = (r_cnt == off_t'(LINE_DW - 1));

    ysyx_22050550_dcache_array u_array (
        .clock       (clock),
        .reset       (reset),
        .i_idx       (w_idx),
        .o_valid     (w_arr_valid),
        .o_tag       (w_arr_tag),
        .o_line      (w_arr_line),
        .i_wr_en     (w_wr),
        .i_wr_word   (w_word),
        .i_wr_data   (r_req.wdata),
        .i_wr_mask   (r_req.wmask),
        .i_fill_en   (w_fill),
        .i_fill_word (r_cnt),
        .i_fill_data (axi.io_r_rdata),
        .i_set_valid (w_set),
        .i_set_tag   (w_tag),
        .i_clr_valid (w_clr)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && lsu.io_Cache_valid) begin
                r_req <= '{op:    lsu.io_Cache_op,
                           addr:  lsu.io_Cache_addr,
                           wdata: lsu.io_Cache_wdata,
                           wmask: lsu.io_Cache_wmask};
            end
            if (r_state == S_R && axi.io_r_valid) r_cnt <= r_cnt + off_t'(1);
        end
    end

    // NOTE: every signal driven here gets a default first, so no case path infers a latch.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_wr   = 1'b0;
        w_fill = 1'b0;
        w_set  = 1'b0;
        unique case (r_state)
            S_IDLE:   if (lsu.io_Cache_valid) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (r_req.op) begin
                    w_next = S_AW;
                    w_wr   = w_hit;
                end else if (w_hit) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_AR;
                    w_clr  = 1'b1;
                end
            end
            S_AR:     if (axi.io_ar_ready) w_next = S_R;
            S_R: begin
                if (axi.io_r_valid) begin
                    w_fill = 1'b1;
                    if (w_last_beat) begin
                        w_set  = 1'b1;
                        w_next = S_DONE;
                    end
                end
            end
            S_AW:     if (axi.io_aw_ready) w_next = S_W;
            S_W:      if (axi.io_w_ready) w_next = S_B;
            S_B:      if (axi.io_b_valid) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign axi.io_ar_valid = (r_state == S_AR);
    assign axi.io_ar_addr  = {r_req.addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
    assign axi.io_ar_len   = AXI_LEN_LINE;
    assign axi.io_ar_size  = AXI_SIZE_8B;
    assign axi.io_ar_burst = AXI_BURST_INCR;
    assign axi.io_r_ready  = (r_state == S_R);

    assign axi.io_aw_valid = (r_state == S_AW);
    assign axi.io_aw_addr  = {r_req.addr[ADDR_W-1:3], 3'b000};
    assign axi.io_aw_len   = AXI_LEN_SINGLE;
    assign axi.io_aw_size  = AXI_SIZE_8B;
    assign axi.io_aw_burst = AXI_BURST_INCR;
    assign axi.io_w_valid  = (r_state == S_W);
    assign axi.io_w_data   = r_req.wdata;
    assign axi.io_w_strb   = r_req.wmask;
    assign axi.io_w_last   = 1'b1;
    assign axi.io_b_ready  = (r_state == S_B);

    // Load data is read from the array only after the refill has landed.
    assign lsu.io_Cache_dataok = (r_state == S_DONE);
    assign lsu.io_Cache_data   = (r_state == S_DONE)
                               ? (w_arr_line[w_word] >> {r_req.addr[2:0], 3'b000})
                               : 64'd0;

    a_rlast_on_last_beat: assert property (@(posedge clock) disable iff (!reset)
        (r_state == S_R && axi.io_r_valid && w_last_beat) |-> axi.io_r_rlast);

endmodule

// File: tb/tb_ysyx_22050550_dcache.sv
// Self-checking bench for ysyx_22050550_dcache: directed vector table, randomized traffic
// with AXI stalls against a line-residency model, and a reset during a refill burst.
module tb_ysyx_22050550_dcache;
    import ysyx_22050550_dcache_pkg::*;

    localparam int LINE_B = 8 * LINE_DW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_22050550_dcache_lsu_if lsu ();
    ysyx_22050550_dcache_axi_if axi ();

    ysyx_22050550_dcache dut (
        .clock (clock),
        .reset (reset),
        .lsu   (lsu),
        .axi   (axi)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Memory behind the AXI port, and an independent shadow of what memory should hold
    logic [63:0] slv_mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] fill_pattern(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_A5A5, ~a[31:0]};
    endfunction

    function automatic logic [63:0] slv_rd(input logic [63:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : fill_pattern(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill_pattern(a);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        slv_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Cache model: which line (by base address) each set currently holds
    bit          m_v    [NSET];
    logic [63:0] m_line [NSET];

    // AXI slave state
    bit          stall_en = 1'b0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit          ar_pend, aw_pend, b_pend;
    logic [63:0] ar_addr_s, aw_addr_s, w_data_s;
    logic [7:0]  ar_len_s, w_strb_s;
    logic [63:0] rd_base, wr_addr;
    int          rd_left, rd_beat, b_left;
    int          ar_wait, r_wait, aw_wait, b_wait;
    int          n_ar = 0, n_aw = 0;
    logic [63:0] last_ar_addr, last_aw_addr, last_w_data;
    logic [7:0]  last_ar_len, last_aw_len, last_w_strb;
    logic [2:0]  last_ar_size;
    logic [1:0]  last_ar_burst;
    logic        last_w_last;

    function automatic int pick();
        return stall_en ? int'($urandom_range(0, 7)) : 0;
    endfunction

    task automatic slave_clear();
        {ar_hs, r_hs, aw_hs, w_hs, b_hs} = '0;
        {ar_pend, aw_pend, b_pend} = '0;
        rd_left = 0; rd_beat = 0; b_left = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; b_wait = 0;
        axi.io_ar_ready = 1'b0;
        axi.io_r_valid  = 1'b0;
        axi.io_r_rdata  = '0;
        axi.io_r_rlast  = 1'b0;
        axi.io_aw_ready = 1'b0;
        axi.io_w_ready  = 1'b0;
        axi.io_b_valid  = 1'b0;
    endtask

    // Called between edges: retire the handshakes of the last posedge, then drive the next cycle
    task automatic slave_step();
        if (!reset) begin
            slave_clear();
            return;
        end
        if (ar_pend) check("ar_valid_held", axi.io_ar_valid, 1'b1);
        if (aw_pend) check("aw_valid_held", axi.io_aw_valid, 1'b1);
        if (b_pend)  check("b_ready_held", axi.io_b_ready, 1'b1);
        if (axi.io_ar_valid || axi.io_aw_valid)
            check("ar_aw_exclusive", axi.io_ar_valid & axi.io_aw_valid, 1'b0);

        if (ar_hs) begin
            rd_base = ar_addr_s; rd_left = int'(ar_len_s) + 1; rd_beat = 0;
            n_ar++; ar_wait = pick(); r_wait = pick();
        end
        if (r_hs) begin
            rd_beat++; rd_left--; r_wait = pick();
        end
        if (aw_hs) begin
            wr_addr = aw_addr_s; n_aw++; aw_wait = pick();
        end
        if (w_hs) begin
            slv_mem[wr_addr] = merge(slv_rd(wr_addr), w_data_s, w_strb_s);
            b_left = 1; b_wait = pick();
        end
        if (b_hs) b_left = 0;

        axi.io_ar_ready = 1'b0;
        if (axi.io_ar_valid) begin
            if (ar_wait == 0) axi.io_ar_ready = 1'b1;
            else ar_wait--;
        end
        axi.io_r_valid = 1'b0;
        axi.io_r_rlast = 1'b0;
        axi.io_r_rdata = '0;
        if (rd_left > 0) begin
            if (r_wait == 0) begin
                axi.io_r_valid = 1'b1;
                axi.io_r_rdata = slv_rd(rd_base + 64'(8 * rd_beat));
                axi.io_r_rlast = (rd_left == 1);
            end else r_wait--;
        end
        axi.io_aw_ready = 1'b0;
        if (axi.io_aw_valid) begin
            if (aw_wait == 0) axi.io_aw_ready = 1'b1;
            else aw_wait--;
        end
        axi.io_w_ready = axi.io_w_valid;
        axi.io_b_valid = 1'b0;
        if (b_left > 0) begin
            if (b_wait == 0) axi.io_b_valid = 1'b1;
            else b_wait--;
        end

        ar_hs   = axi.io_ar_valid && axi.io_ar_ready;
        ar_pend = axi.io_ar_valid && !axi.io_ar_ready;
        ar_addr_s = axi.io_ar_addr;
        ar_len_s  = axi.io_ar_len;
        if (ar_hs) begin
            last_ar_addr = axi.io_ar_addr; last_ar_len = axi.io_ar_len;
            last_ar_size = axi.io_ar_size; last_ar_burst = axi.io_ar_burst;
        end
        r_hs    = axi.io_r_valid && axi.io_r_ready;
        aw_hs   = axi.io_aw_valid && axi.io_aw_ready;
        aw_pend = axi.io_aw_valid && !axi.io_aw_ready;
        aw_addr_s = axi.io_aw_addr;
        if (aw_hs) begin
            last_aw_addr = axi.io_aw_addr; last_aw_len = axi.io_aw_len;
        end
        w_hs     = axi.io_w_valid && axi.io_w_ready;
        w_data_s = axi.io_w_data;
        w_strb_s = axi.io_w_strb;
        if (w_hs) begin
            last_w_data = axi.io_w_data; last_w_strb = axi.io_w_strb; last_w_last = axi.io_w_last;
        end
        b_hs   = axi.io_b_valid && axi.io_b_ready;
        b_pend = axi.io_b_ready && !axi.io_b_valid;
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge clock);
            #2;
            slave_step();
        end
    end

    // One LSU request, entered and left at a negedge with the cache idle
    task automatic run_one(input string name, input bit op, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           output int lat, output logic [63:0] data);
        int          ar0, aw0, idx;
        bit          hit, done;
        logic [63:0] dw, line;
        dw   = addr & ~64'h7;
        line = addr & ~64'(LINE_B - 1);
        idx  = int'((addr / LINE_B) % NSET);
        hit  = m_v[idx] && (m_line[idx] == line);
        ar0  = n_ar;
        aw0  = n_aw;

        lsu.io_Cache_valid = 1'b1;
        lsu.io_Cache_op    = op;
        lsu.io_Cache_addr  = addr;
        lsu.io_Cache_wdata = wdata;
        lsu.io_Cache_wmask = wmask;
        lat  = 0;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (lsu.io_Cache_dataok) begin
                done = 1'b1;
                break;
            end
        end
        data = lsu.io_Cache_data;
        lsu.io_Cache_valid = 1'b0;
        lsu.io_Cache_addr  = $urandom;
        lsu.io_Cache_wdata = {$urandom, $urandom};
        @(negedge clock);

        check({name, " done"}, done, 1'b1);
        check({name, " ar_count"}, 64'(n_ar - ar0), 64'(!op && !hit));
        check({name, " aw_count"}, 64'(n_aw - aw0), 64'(op));
        if (!op) begin
            check({name, " rdata"}, data, ref_rd(dw) >> (8 * addr[2:0]));
            if (!hit) begin
                check({name, " ar_addr"}, last_ar_addr, line);
                check({name, " ar_len"}, last_ar_len, 64'(LINE_DW - 1));
                check({name, " ar_size_burst"}, {last_ar_size, last_ar_burst}, 5'b011_01);
            end
            m_v[idx]    = 1'b1;
            m_line[idx] = line;
        end else begin
            check({name, " aw_addr"}, last_aw_addr, dw);
            check({name, " aw_len"}, last_aw_len, 0);
            check({name, " w_strb"}, last_w_strb, wmask);
            check({name, " w_data"}, last_w_data, wdata);
            check({name, " w_last"}, last_w_last, 1'b1);
            ref_mem[dw] = merge(ref_rd(dw), wdata, wmask);
        end
        if (!stall_en) check({name, " latency"}, lat, (!op && hit) ? 2 : 5);
    endtask

    typedef struct {
        bit          op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          lat;
        logic [63:0] data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          lat;
        logic [63:0] data;
        bit          seen;

        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [63:0] data;
        bit          seen;

        vecs[0]  = '{1'b0, 64'h8000_0008, 64'h0, 8'h00, 5, 64'h1122_3344_5566_7788};
        vecs[1]  = '{1'b0, 64'h8000_0008, 64'h0, 8'h00, 2, 64'h1122_3344_5566_7788};
        vecs[2]  = '{1'b0, 64'h8000_0004, 64'h0, 8'h00, 2, 64'h0000_0000_0102_0304};
        vecs[3]  = '{1'b1, 64'h8000_0008, 64'hAABB_CCDD_0000_0000, 8'hF0, 5, 64'h0};
        vecs[4]  = '{1'b0, 64'h8000_0008, 64'h0, 8'h00, 2, 64'hAABB_CCDD_5566_7788};
        vecs[5]  = '{1'b1, 64'h8000_1000, 64'h0000_0000_1234_5678, 8'h0F, 5, 64'h0};
        vecs[6]  = '{1'b0, 64'h8000_0008, 64'h0, 8'h00, 2, 64'hAABB_CCDD_5566_7788};
        vecs[7]  = '{1'b0, 64'h8000_1000, 64'h0, 8'h00, 5, 64'hCAFE_BABE_1234_5678};
        vecs[8]  = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 5, 64'h0102_0304_0506_0708};
        vecs[9]  = '{1'b0, 64'h8000_0100, 64'h0, 8'h00, 5, 64'h0F0E_0D0C_0B0A_0908};
        vecs[10] = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 5, 64'h0102_0304_0506_0708};
        vecs[11] = '{1'b0, 64'h8000_0003, 64'h0, 8'h00, 2, 64'h0000_0001_0203_0405};
        vecs[12] = '{1'b0, 64'h8000_000F, 64'h0, 8'h00, 2, 64'h0000_0000_0000_00AA};

        preload(64'h8000_0000, 64'h0102_0304_0506_0708);
        preload(64'h8000_0008, 64'h1122_3344_5566_7788);
        preload(64'h8000_0100, 64'h0F0E_0D0C_0B0A_0908);
        preload(64'h8000_1000, 64'hCAFE_BABE_DEAD_BEEF);
        for (int i = 0; i < NSET; i++) m_v[i] = 1'b0;

        lsu.io_Cache_valid = 1'b0;
        lsu.io_Cache_op    = 1'b0;
        lsu.io_Cache_addr  = '0;
        lsu.io_Cache_wdata = '0;
        lsu.io_Cache_wmask = '0;

        repeat (2) @(negedge clock);
        check("reset dataok", lsu.io_Cache_dataok, 1'b0);
        check("reset data", lsu.io_Cache_data, 64'h0);
        check("reset ar_aw_w_valid", {axi.io_ar_valid, axi.io_aw_valid, axi.io_w_valid}, 3'b000);
        check("reset r_b_ready", {axi.io_r_ready, axi.io_b_ready}, 2'b00);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                    vecs[i].wmask, lat, data);
            check($sformatf("vec%0d table_latency", i), lat, vecs[i].lat);
            if (!vecs[i].op) check($sformatf("vec%0d table_data", i), data, vecs[i].data);
        end

        stall_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            bit          op;
            logic [63:0] addr;
            op   = ($urandom_range(0, 2) == 0);
            addr = 64'h8000_0000 + 64'($urandom_range(0, 3) * 256)
                                 + 64'($urandom_range(0, 3) * LINE_B)
                                 + 64'($urandom_range(0, LINE_B - 1));
            run_one($sformatf("rnd%0d", i), op, addr, {$urandom, $urandom},
                    8'($urandom_range(1, 255)), lat, data);
        end

        // Reset while a refill burst is in progress
        stall_en = 1'b0;
        lsu.io_Cache_valid = 1'b1;
        lsu.io_Cache_op    = 1'b0;
        lsu.io_Cache_addr  = 64'h8000_3020;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (axi.io_r_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("midR reached_R", seen, 1'b1);
        reset = 1'b0;
        #1;
        check("midR dataok", lsu.io_Cache_dataok, 1'b0);
        check("midR data", lsu.io_Cache_data, 64'h0);
        check("midR ar_aw_w_valid", {axi.io_ar_valid, axi.io_aw_valid, axi.io_w_valid}, 3'b000);
        check("midR r_b_ready", {axi.io_r_ready, axi.io_b_ready}, 2'b00);
        lsu.io_Cache_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < NSET; i++) m_v[i] = 1'b0;
        @(negedge clock);
        run_one("post_reset", 1'b0, 64'h8000_0008, 64'h0, 8'h00, lat, data);
        check("post_reset latency_miss", lat, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
